// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, FSM state type and arctangent table (radians * 2^13).
// Used by the vectoring block and the rotation block.
package cordic_pkg;

  localparam int ITERATIONS      = 13;
  localparam int INT_WIDTH       = 18;
  localparam int PHASE_WIDTH     = 16;
  localparam int HALF_PI         = 12868;
  localparam int PI              = 25736;
  localparam int GAIN_COMP       = 4975;
  localparam int GAIN_COMP_SHIFT = 13;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    OUT
  } cordic_state_t;

  function automatic logic signed [PHASE_WIDTH-1:0] atan_angle(input logic [3:0] idx);
    logic signed [PHASE_WIDTH-1:0] angle;
    case (idx)
      4'd0:    angle = 16'sd6434;
      4'd1:    angle = 16'sd3798;
      4'd2:    angle = 16'sd2007;
      4'd3:    angle = 16'sd1019;
      4'd4:    angle = 16'sd511;
      4'd5:    angle = 16'sd256;
      4'd6:    angle = 16'sd128;
      4'd7:    angle = 16'sd64;
      4'd8:    angle = 16'sd32;
      4'd9:    angle = 16'sd16;
      4'd10:   angle = 16'sd8;
      4'd11:   angle = 16'sd4;
      4'd12:   angle = 16'sd2;
      default: angle = '0;
    endcase
    return angle;
  endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// Registered CORDIC gain compensation: mag_out = (mag_in * GAIN_COMP) >> GAIN_COMP_SHIFT,
// built from shifted copies of mag_in selected by the coefficient bits.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int MAG_WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 in_valid,
  input  logic [MAG_WIDTH-1:0] mag_in,
  output logic                 out_valid,
  output logic [MAG_WIDTH-1:0] mag_out
);

  localparam int COEF_WIDTH = GAIN_COMP_SHIFT;
  localparam int PROD_WIDTH = MAG_WIDTH + COEF_WIDTH;
  localparam logic [COEF_WIDTH-1:0] COEF = COEF_WIDTH'(GAIN_COMP);

  logic [PROD_WIDTH-1:0] term [COEF_WIDTH];
  logic [PROD_WIDTH-1:0] prod;
  logic                  unused_frac;

  genvar gi;
  generate
    for (gi = 0; gi < COEF_WIDTH; gi++) begin : g_term
      assign term[gi] = COEF[gi] ? (PROD_WIDTH'(mag_in) << gi) : '0;
    end
  endgenerate

  always_comb begin
    prod = '0;
    for (int i = 0; i < COEF_WIDTH; i++) begin
      prod = prod + term[i];
    end
  end

  // Fractional bits are truncated away by the final shift.
  assign unused_frac = ^prod[GAIN_COMP_SHIFT-1:0];

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      out_valid <= 1'b0;
      mag_out   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        mag_out <= prod[GAIN_COMP_SHIFT +: MAG_WIDTH];
      end
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring: (x,y) -> magnitude and atan2 phase (radians * 2^13).
// Define CORDIC_VEC_GAIN_COMP_EN to scale mag_out by 1/1.6468 at the cost of one extra cycle.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int DATAIN_WIDTH = 16,
  parameter int ITERATIONS   = cordic_pkg::ITERATIONS
) (
  input  logic                           clk,
  input  logic                           sclr,
  input  logic                           nd,
  input  logic signed [DATAIN_WIDTH-1:0] x_in,
  input  logic signed [DATAIN_WIDTH-1:0] y_in,
  output logic                           busy,
  output logic                           rdy,
  output logic [DATAIN_WIDTH:0]          mag_out,
  output logic signed [DATAIN_WIDTH-1:0] phase_out
);

  cordic_state_t                  state_reg;
  logic [3:0]                     count_reg;
  logic signed [INT_WIDTH-1:0]    x_reg, y_reg;
  logic signed [PHASE_WIDTH-1:0]  z_reg;
  logic                           zero_reg;
  logic                           fin_reg;
  logic [DATAIN_WIDTH:0]          res_mag_reg;
  logic signed [DATAIN_WIDTH-1:0] res_phase_reg;

  logic signed [INT_WIDTH-1:0]    x_ext, y_ext, x_fold, y_fold;
  logic signed [PHASE_WIDTH-1:0]  z_fold;
  logic signed [INT_WIDTH-1:0]    x_shift, y_shift, x_step, y_step;
  logic signed [PHASE_WIDTH-1:0]  z_step;
  logic                           done;
  logic [DATAIN_WIDTH:0]          done_mag;

  assign x_ext = INT_WIDTH'(x_in);
  assign y_ext = INT_WIDTH'(y_in);

  // Rotate left-half-plane inputs by +/-90 degrees so the iterations start within convergence range.
  always_comb begin
    x_fold = x_ext;
    y_fold = y_ext;
    z_fold = '0;
    if (x_ext[INT_WIDTH-1]) begin
      if (!y_ext[INT_WIDTH-1]) begin
        x_fold = y_ext;
        y_fold = -x_ext;
        z_fold = PHASE_WIDTH'(HALF_PI);
      end else begin
        x_fold = -y_ext;
        y_fold = x_ext;
        z_fold = -PHASE_WIDTH'(HALF_PI);
      end
    end
  end

  always_comb begin
    x_shift = x_reg >>> count_reg;
    y_shift = y_reg >>> count_reg;
    if (!y_reg[INT_WIDTH-1]) begin
      x_step = x_reg + y_shift;
      y_step = y_reg - x_shift;
      z_step = z_reg + atan_angle(count_reg);
    end else begin
      x_step = x_reg - y_shift;
      y_step = y_reg + x_shift;
      z_step = z_reg - atan_angle(count_reg);
    end
  end

`ifdef CORDIC_VEC_GAIN_COMP_EN
  cordic_gain_comp #(
    .MAG_WIDTH(DATAIN_WIDTH + 1)
  ) u_gain_comp (
    .clk      (clk),
    .sclr     (sclr),
    .in_valid (fin_reg),
    .mag_in   (res_mag_reg),
    .out_valid(done),
    .mag_out  (done_mag)
  );
`else
  assign done     = fin_reg;
  assign done_mag = res_mag_reg;
`endif

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      zero_reg      <= 1'b0;
      fin_reg       <= 1'b0;
      res_mag_reg   <= '0;
      res_phase_reg <= '0;
      busy          <= 1'b0;
      rdy           <= 1'b0;
      mag_out       <= '0;
      phase_out     <= '0;
    end else begin
      fin_reg <= 1'b0;
      rdy     <= done;
      if (done) begin
        mag_out   <= done_mag;
        phase_out <= res_phase_reg;
        busy      <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          // busy stays high through the output stage, so nd is only taken once rdy has fired.
          if (nd && !busy) begin
            x_reg     <= x_fold;
            y_reg     <= y_fold;
            z_reg     <= z_fold;
            zero_reg  <= (x_in == '0) && (y_in == '0);
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= ITER;
          end
        end
        ITER: begin
          x_reg <= x_step;
          y_reg <= y_step;
          z_reg <= z_step;
          if (count_reg == 4'(ITERATIONS - 1)) begin
            count_reg <= '0;
            state_reg <= OUT;
          end else begin
            count_reg <= count_reg + 4'd1;
          end
        end
        OUT: begin
          res_mag_reg   <= zero_reg ? '0 : x_reg[DATAIN_WIDTH:0];
          res_phase_reg <= zero_reg ? '0 : DATAIN_WIDTH'(z_reg);
          fin_reg       <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
